outport_uart_tx: RTL and testbench
==================================

# outport_uart_tx

Serial debug tap downstream of the datapath output port. It captures every 32-bit word written to the output port and buffers it in a small word FIFO. Each word is then shifted out on a single UART TX line as four 8N1 bytes, least-significant byte first. The block is instantiated beside the seven-segment drivers. It is fed by the output-port data and the control unit's output-port write strobe, so program output can be logged at the bench and on hardware.

## Interface
- CLKS_PER_BIT, default 434: clock cycles per UART bit (50 MHz / 115200); legal range 2..65535.
- FIFO_DEPTH, default 4: word entries; power of two, 2..16.

- clk  input  1  system clock; all logic on rising edge.
- reset  input  1  synchronous, active-high; one clock; reset is synchronous and active-high.
- in_write  input  1  output-port write strobe; one word is pushed per cycle in which it is high.
- in_data  input  32  word to log; sampled on the same edge as in_write.
- out_tx  output  1  UART line; idle high.
- out_busy  output  1  high while the FIFO is non-empty or a frame is in progress.
- out_full  output  1  FIFO holds FIFO_DEPTH words.
- out_overflow  output  1  sticky; set when a push is dropped; cleared only by reset.

## Operation
- FIFO: registered read/write pointers of width log2(FIFO_DEPTH) that wrap naturally, plus a count of width log2(FIFO_DEPTH)+1.
- Push rule: accept the push when in_write=1 and either count<FIFO_DEPTH or a pop occurs in the same cycle.
  - Push and pop in the same cycle leave count unchanged.
  - A push at full with no pop is dropped, and out_overflow is set on that edge.
- FSM states: IDLE, START, DATA, STOP.
- IDLE: if count≠0, pop the head word into a 32-bit shift register, set byte_idx=0 and the bit timer to CLKS_PER_BIT-1, and go to START. Otherwise stay in IDLE.
- START: out_tx=0 for CLKS_PER_BIT cycles, then go to DATA with bit_idx=0.
- DATA: out_tx = shift[0] for CLKS_PER_BIT cycles per bit. After each bit, shift right by 1. After bit_idx=7, go to STOP.
- STOP: out_tx=1 for CLKS_PER_BIT cycles. Then:
  - If byte_idx<3: increment byte_idx and go to START.
  - If byte_idx=3 and count≠0: pop the next word and go to START directly, with no idle bit.
  - If byte_idx=3 and count=0: go to IDLE.
- Byte order on the line: in_data[7:0], [15:8], [23:16], [31:24], each LSB first.
- out_tx is driven from a register, never combinationally.
- out_busy = (state≠IDLE) | (count≠0).
- out_full = (count==FIFO_DEPTH).
- Outputs after reset: out_tx=1, out_busy=0, out_full=0, out_overflow=0. Internally: state=IDLE, count=0, both pointers=0.
- Reset mid-frame: the frame is aborted, out_tx is high from the next edge, and FIFO contents are discarded.
- Reset has priority over a simultaneous in_write, which is dropped.

## Timing
- in_write sampled at edge k:
  - count=1 after edge k.
  - The FSM pops at edge k+1, and out_tx falls at edge k+1.
- Word frame length: exactly 40·CLKS_PER_BIT cycles from the start-bit falling edge to the end of the last stop bit.
- Back-to-back words: the next start bit begins the cycle immediately after the previous stop bit ends.
- out_full asserts on the edge where the push makes count reach FIFO_DEPTH. It deasserts on the edge of the pop.
- out_overflow asserts on the edge of the dropped push.
- Throughput ceiling: one word per 40·CLKS_PER_BIT cycles. The CPU must not out-write this by more than FIFO_DEPTH words.

## Test plan
Benches use CLKS_PER_BIT=4 and FIFO_DEPTH=4.

1. Reset state: assert reset for 3 cycles and release.
   - Expect out_tx=1, out_busy=0, out_full=0, out_overflow=0.
   - out_tx stays high for 100 cycles with no writes.
2. Single word: in_write pulse with in_data=0x12345678.
   - out_tx falls 1 cycle later.
   - Sampling mid-bit decodes bytes 0x78, 0x56, 0x34, 0x12, each framed 0…1.
   - Total 160 cycles, then out_busy=0.
3. Back-to-back: write 0xDEADBEEF and 0x00000001 on consecutive cycles.
   - Expect 320 continuous cycles decoding EF BE AD DE 01 00 00 00, with no idle gap between words.
4. Full and overflow: write 6 words on consecutive cycles (0x1..0x6).
   - Word 0x1 is popped one cycle after its write, so 0x2..0x5 fill the FIFO.
   - out_full=1 after the 5th write; the 6th write is dropped and out_overflow=1.
   - Line carries words 1,2,3,4,5 only; out_overflow stays 1 until reset.
5. Push and pop in the same cycle at full: hold the FIFO full and issue in_write on the exact cycle the FSM pops.
   - The write is accepted, count stays at 4, and out_overflow remains 0.
6. Reset mid-frame: write 0x000000FF and assert reset during DATA of byte 0.
   - out_tx=1 on the next edge, and out_busy=0.
   - A subsequent write of 0x000000AA transmits correctly.

Source files
------------

// File: rtl/outport_uart_tx.sv
// outport_uart_tx: logs every word written to the output port over a UART line.
// Words are queued in a small FIFO. Each word is then sent as four 8N1 bytes,
// least-significant byte first, with no idle gap between queued words.
module outport_uart_tx #(
  parameter int CLKS_PER_BIT = 434,
  parameter int FIFO_DEPTH   = 4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        in_write,
  input  logic [31:0] in_data,
  output logic        out_tx,
  output logic        out_busy,
  output logic        out_full,
  output logic        out_overflow
);

  localparam int PW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int CW = PW + 1;
  localparam int TW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [TW-1:0] BIT_LAST = TW'(CLKS_PER_BIT - 1);
  localparam logic [CW-1:0] DEPTH_C  = CW'(FIFO_DEPTH);

  typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

  // FIFO storage and bookkeeping
  logic [31:0]   r_mem [FIFO_DEPTH];
  logic [PW-1:0] r_wr_ptr;
  logic [PW-1:0] r_rd_ptr;
  logic [CW-1:0] r_count;
  logic          r_overflow;

  // Transmitter state
  state_t        r_state;
  logic [31:0]   r_shift;
  logic [TW-1:0] r_timer;
  logic [2:0]    r_bit_idx;
  logic [1:0]    r_byte_idx;
  logic          r_tx;

  // Next-state values from the FSM
  state_t        w_state_next;
  logic [31:0]   w_shift_next;
  logic [TW-1:0] w_timer_next;
  logic [2:0]    w_bit_idx_next;
  logic [1:0]    w_byte_idx_next;
  logic          w_tx_next;
  logic          w_pop;

  logic          w_push;
  logic          w_drop;
  logic          w_bit_done;
  logic [31:0]   w_head;

  // A push at full is still accepted when the FSM frees a slot on the same edge
  assign w_push     = in_write & ((r_count != DEPTH_C) | w_pop);
  assign w_drop     = in_write & ~w_push;
  assign w_bit_done = (r_timer == '0);
  assign w_head     = r_mem[r_rd_ptr];

  // FIFO storage write; contents need no reset since count gates validity
  always_ff @(posedge clk) begin
    if (w_push) begin
      r_mem[r_wr_ptr] <= in_data;
    end
  end

  // FIFO pointers, occupancy and sticky overflow flag
  always_ff @(posedge clk) begin
    if (reset) begin
      r_wr_ptr   <= '0;
      r_rd_ptr   <= '0;
      r_count    <= '0;
      r_overflow <= 1'b0;
    end else begin
      if (w_push) begin
        r_wr_ptr <= r_wr_ptr + 1'b1;
      end
      if (w_pop) begin
        r_rd_ptr <= r_rd_ptr + 1'b1;
      end
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
      if (w_drop) begin
        r_overflow <= 1'b1;
      end
    end
  end

  // Transmitter register bank, including the registered line output
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state    <= IDLE;
      r_shift    <= '0;
      r_timer    <= BIT_LAST;
      r_bit_idx  <= '0;
      r_byte_idx <= '0;
      r_tx       <= 1'b1;
    end else begin
      r_state    <= w_state_next;
      r_shift    <= w_shift_next;
      r_timer    <= w_timer_next;
      r_bit_idx  <= w_bit_idx_next;
      r_byte_idx <= w_byte_idx_next;
      r_tx       <= w_tx_next;
    end
  end

  // Frame sequencing: start bit, eight data bits, stop bit, four bytes per word
  always_comb begin
    w_state_next    = r_state;
    w_shift_next    = r_shift;
    w_timer_next    = w_bit_done ? BIT_LAST : r_timer - 1'b1;
    w_bit_idx_next  = r_bit_idx;
    w_byte_idx_next = r_byte_idx;
    w_pop           = 1'b0;

    case (r_state)
      IDLE: begin
        w_timer_next = BIT_LAST;
        if (r_count != '0) begin
          w_pop           = 1'b1;
          w_shift_next    = w_head;
          w_byte_idx_next = 2'd0;
          w_state_next    = START;
        end
      end
      START: begin
        if (w_bit_done) begin
          w_bit_idx_next = 3'd0;
          w_state_next   = DATA;
        end
      end
      DATA: begin
        if (w_bit_done) begin
          w_shift_next = r_shift >> 1;
          if (r_bit_idx == 3'd7) begin
            w_state_next = STOP;
          end else begin
            w_bit_idx_next = r_bit_idx + 3'd1;
          end
        end
      end
      STOP: begin
        if (w_bit_done) begin
          if (r_byte_idx != 2'd3) begin
            w_byte_idx_next = r_byte_idx + 2'd1;
            w_state_next    = START;
          end else if (r_count != '0) begin
            // Chain straight into the next word without an idle bit
            w_pop           = 1'b1;
            w_shift_next    = w_head;
            w_byte_idx_next = 2'd0;
            w_state_next    = START;
          end else begin
            w_state_next = IDLE;
          end
        end
      end
      default: begin
        w_state_next = IDLE;
      end
    endcase

    // Line level follows the state being entered so out_tx stays registered
    case (w_state_next)
      START:   w_tx_next = 1'b0;
      DATA:    w_tx_next = w_shift_next[0];
      default: w_tx_next = 1'b1;
    endcase
  end

  assign out_tx       = r_tx;
  assign out_busy     = (r_state != IDLE) | (r_count != '0);
  assign out_full     = (r_count == DEPTH_C);
  assign out_overflow = r_overflow;

endmodule

// File: tb/tb_outport_uart_tx.sv
// Directed bench for outport_uart_tx with 4 clocks per bit and a 4-word FIFO.
module tb_outport_uart_tx;

  localparam int CPB   = 4;
  localparam int DEPTH = 4;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        in_write = 1'b0;
  logic [31:0] in_data = '0;
  logic        out_tx;
  logic        out_busy;
  logic        out_full;
  logic        out_overflow;

  int checks = 0;
  int errors = 0;

  outport_uart_tx #(
    .CLKS_PER_BIT(CPB),
    .FIFO_DEPTH  (DEPTH)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .in_write    (in_write),
    .in_data     (in_data),
    .out_tx      (out_tx),
    .out_busy    (out_busy),
    .out_full    (out_full),
    .out_overflow(out_overflow)
  );

  always #5 clk = ~clk;

  // Hard time limit so the run always ends
  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // Hold reset for three rising edges, release on a falling edge
  task automatic do_reset();
    reset    = 1'b1;
    in_write = 1'b0;
    repeat (3) @(negedge clk);
    reset = 1'b0;
  endtask

  // Entered on the falling edge inside the first cycle of a start bit; samples
  // every bit two cycles in and returns on the first cycle after the frame
  task automatic recv_word(output logic [31:0] w, output logic frame_bad);
    logic [7:0] by;
    w         = '0;
    by        = '0;
    frame_bad = 1'b0;
    for (int i = 0; i < 4; i++) begin
      for (int b = 0; b < 10; b++) begin
        repeat (2) @(negedge clk);
        if (b == 0) begin
          if (out_tx !== 1'b0) frame_bad = 1'b1;
        end else if (b == 9) begin
          if (out_tx !== 1'b1) frame_bad = 1'b1;
        end else begin
          by[b-1] = out_tx;
        end
        repeat (2) @(negedge clk);
      end
      w[8*i +: 8] = by;
    end
  endtask

  // Advance falling edges until the line goes low, bounded
  task automatic wait_start(output logic found);
    found = 1'b0;
    for (int i = 0; i < 400 && !found; i++) begin
      @(negedge clk);
      if (out_tx === 1'b0) found = 1'b1;
    end
  endtask

  task automatic test_reset();
    int low_seen;
    do_reset();
    checks++;
    if (out_tx !== 1'b1) begin errors++; $display("FAIL reset_tx: got %b expected 1", out_tx); end
    else $display("reset_tx ok");
    checks++;
    if (out_busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b expected 0", out_busy); end
    else $display("reset_busy ok");
    checks++;
    if (out_full !== 1'b0) begin errors++; $display("FAIL reset_full: got %b expected 0", out_full); end
    else $display("reset_full ok");
    checks++;
    if (out_overflow !== 1'b0) begin errors++; $display("FAIL reset_overflow: got %b expected 0", out_overflow); end
    else $display("reset_overflow ok");
    low_seen = 0;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (out_tx !== 1'b1) low_seen++;
    end
    checks++;
    if (low_seen != 0) begin errors++; $display("FAIL idle_line: got %0d low cycles expected 0", low_seen); end
    else $display("idle_line ok: 100 cycles high");
  endtask

  task automatic test_single_word();
    logic [31:0] w;
    logic        bad;
    do_reset();
    in_write = 1'b1;
    in_data  = 32'h12345678;
    @(negedge clk);
    in_write = 1'b0;
    checks++;
    if (out_tx !== 1'b1 || out_busy !== 1'b1) begin
      errors++; $display("FAIL single_pre_start: got tx=%b busy=%b expected tx=1 busy=1", out_tx, out_busy);
    end else $display("single_pre_start ok");
    @(negedge clk);
    checks++;
    if (out_tx !== 1'b0) begin errors++; $display("FAIL single_start_edge: got %b expected 0", out_tx); end
    else $display("single_start_edge ok");
    recv_word(w, bad);
    checks++;
    if (w !== 32'h12345678 || bad) begin
      errors++; $display("FAIL single_word: got %h framing_bad=%b expected 12345678 framing_bad=0", w, bad);
    end else $display("single_word ok: %h", w);
    checks++;
    if (out_busy !== 1'b0 || out_tx !== 1'b1) begin
      errors++; $display("FAIL single_done: got busy=%b tx=%b expected busy=0 tx=1", out_busy, out_tx);
    end else $display("single_done ok after 160 cycles");
  endtask

  task automatic test_back_to_back();
    logic [31:0] w0, w1;
    logic        bad0, bad1;
    do_reset();
    in_write = 1'b1;
    in_data  = 32'hDEADBEEF;
    @(negedge clk);
    in_data  = 32'h00000001;
    @(negedge clk);
    in_write = 1'b0;
    checks++;
    if (out_tx !== 1'b0) begin errors++; $display("FAIL b2b_start_edge: got %b expected 0", out_tx); end
    else $display("b2b_start_edge ok");
    recv_word(w0, bad0);
    recv_word(w1, bad1);
    checks++;
    if (w0 !== 32'hDEADBEEF || bad0) begin
      errors++; $display("FAIL b2b_word0: got %h framing_bad=%b expected deadbeef framing_bad=0", w0, bad0);
    end else $display("b2b_word0 ok: %h", w0);
    checks++;
    if (w1 !== 32'h00000001 || bad1) begin
      errors++; $display("FAIL b2b_word1: got %h framing_bad=%b expected 00000001 framing_bad=0", w1, bad1);
    end else $display("b2b_word1 ok: %h", w1);
    checks++;
    if (out_busy !== 1'b0) begin errors++; $display("FAIL b2b_done: got busy=%b expected 0", out_busy); end
    else $display("b2b_done ok after 320 cycles");
  endtask

  task automatic test_overflow();
    do_reset();
    fork
      begin
        for (int i = 1; i <= 6; i++) begin
          in_write = 1'b1;
          in_data  = 32'(i);
          @(negedge clk);
          if (i == 5) begin
            checks++;
            if (out_full !== 1'b1 || out_overflow !== 1'b0) begin
              errors++; $display("FAIL ovf_full_after5: got full=%b ovf=%b expected full=1 ovf=0", out_full, out_overflow);
            end else $display("ovf_full_after5 ok");
          end
        end
        in_write = 1'b0;
        checks++;
        if (out_overflow !== 1'b1 || out_full !== 1'b1) begin
          errors++; $display("FAIL ovf_flag: got ovf=%b full=%b expected ovf=1 full=1", out_overflow, out_full);
        end else $display("ovf_flag ok");
      end
      begin
        logic        found;
        logic [31:0] w;
        logic        bad;
        wait_start(found);
        checks++;
        if (!found) begin errors++; $display("FAIL ovf_start: got no start bit expected one"); end
        for (int k = 1; k <= 5; k++) begin
          recv_word(w, bad);
          checks++;
          if (w !== 32'(k) || bad) begin
            errors++; $display("FAIL ovf_word%0d: got %h framing_bad=%b expected %h", k, w, bad, 32'(k));
          end else $display("ovf_word%0d ok: %h", k, w);
        end
        checks++;
        if (out_busy !== 1'b0 || out_tx !== 1'b1) begin
          errors++; $display("FAIL ovf_no_sixth: got busy=%b tx=%b expected busy=0 tx=1", out_busy, out_tx);
        end else $display("ovf_no_sixth ok");
      end
    join
    repeat (50) @(negedge clk);
    checks++;
    if (out_overflow !== 1'b1) begin errors++; $display("FAIL ovf_sticky: got %b expected 1", out_overflow); end
    else $display("ovf_sticky ok");
  endtask

  task automatic test_push_pop_full();
    do_reset();
    fork
      begin
        for (int i = 1; i <= 5; i++) begin
          in_write = 1'b1;
          in_data  = 32'(i);
          @(negedge clk);
        end
        in_write = 1'b0;
        // First word started one edge after its write; its last stop bit ends
        // 160 cycles later, which is the next pop
        repeat (156) @(negedge clk);
        checks++;
        if (out_full !== 1'b1) begin errors++; $display("FAIL pp_full_before: got %b expected 1", out_full); end
        else $display("pp_full_before ok");
        in_write = 1'b1;
        in_data  = 32'h00000077;
        @(negedge clk);
        in_write = 1'b0;
        checks++;
        if (out_full !== 1'b1 || out_overflow !== 1'b0) begin
          errors++; $display("FAIL pp_same_cycle: got full=%b ovf=%b expected full=1 ovf=0", out_full, out_overflow);
        end else $display("pp_same_cycle ok");
      end
      begin
        logic        found;
        logic [31:0] w;
        logic [31:0] exp_w;
        logic        bad;
        wait_start(found);
        checks++;
        if (!found) begin errors++; $display("FAIL pp_start: got no start bit expected one"); end
        for (int k = 1; k <= 6; k++) begin
          recv_word(w, bad);
          exp_w = (k == 6) ? 32'h00000077 : 32'(k);
          checks++;
          if (w !== exp_w || bad) begin
            errors++; $display("FAIL pp_word%0d: got %h framing_bad=%b expected %h", k, w, bad, exp_w);
          end else $display("pp_word%0d ok: %h", k, w);
        end
        checks++;
        if (out_busy !== 1'b0 || out_overflow !== 1'b0) begin
          errors++; $display("FAIL pp_done: got busy=%b ovf=%b expected busy=0 ovf=0", out_busy, out_overflow);
        end else $display("pp_done ok");
      end
    join
  endtask

  task automatic test_reset_mid_frame();
    logic [31:0] w;
    logic        bad;
    int          activity;
    do_reset();
    in_write = 1'b1;
    in_data  = 32'h000000FF;
    @(negedge clk);
    in_write = 1'b0;
    repeat (6) @(negedge clk);
    // Now in the data bits of byte 0; reset with a competing write
    reset    = 1'b1;
    in_write = 1'b1;
    in_data  = 32'h00000055;
    @(negedge clk);
    reset    = 1'b0;
    in_write = 1'b0;
    checks++;
    if (out_tx !== 1'b1 || out_busy !== 1'b0 || out_full !== 1'b0) begin
      errors++; $display("FAIL mid_reset: got tx=%b busy=%b full=%b expected tx=1 busy=0 full=0", out_tx, out_busy, out_full);
    end else $display("mid_reset ok");
    activity = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (out_tx !== 1'b1 || out_busy !== 1'b0) activity++;
    end
    checks++;
    if (activity != 0) begin errors++; $display("FAIL mid_reset_write_dropped: got %0d active cycles expected 0", activity); end
    else $display("mid_reset_write_dropped ok");
    in_write = 1'b1;
    in_data  = 32'h000000AA;
    @(negedge clk);
    in_write = 1'b0;
    @(negedge clk);
    checks++;
    if (out_tx !== 1'b0) begin errors++; $display("FAIL mid_after_start: got %b expected 0", out_tx); end
    else $display("mid_after_start ok");
    recv_word(w, bad);
    checks++;
    if (w !== 32'h000000AA || bad) begin
      errors++; $display("FAIL mid_after_word: got %h framing_bad=%b expected 000000aa framing_bad=0", w, bad);
    end else $display("mid_after_word ok: %h", w);
    checks++;
    if (out_busy !== 1'b0) begin errors++; $display("FAIL mid_after_done: got busy=%b expected 0", out_busy); end
    else $display("mid_after_done ok");
  endtask

  initial begin
    @(negedge clk);
    test_reset();
    test_single_word();
    test_back_to_back();
    test_overflow();
    test_push_pop_full();
    test_reset_mid_frame();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
